// File: rtl/clk_div_pkg.sv
// Shared types and defaults for the programmable clock divider controller.
// Holds the controller state encoding and the configuration legality rule.
package clk_div_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_PEND,
    ST_DRAIN
  } state_e;

  localparam int CLK_DEF_DIV  = 6;
  localparam int CLK_DEF_HIGH = 2;

  // A period needs at least one low and one high cycle.
  function automatic logic cfg_legal(input int unsigned div, input int unsigned high);
    return (div >= 32'd2) && (high >= 32'd1) && (high < div);
  endfunction

endpackage

// File: rtl/clk_div_core.sv
// Period counter plus duty compare; clk_out is registered and aligned with cnt.
// div_a/high_a must only change while clear is high or on the wrap cycle.
module clk_div_core
  import clk_div_pkg::*;
#(
  parameter int CW = 8
) (
  input  logic          clk_in,
  input  logic          rst,
  input  logic          run,
  input  logic          clear,
  input  logic [CW-1:0] div_a,
  input  logic [CW-1:0] high_a,
  output logic          clk_out,
  output logic          wrap
);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          clk_out_q, clk_out_d;
  logic [CW-1:0] low_len;

  assign low_len = div_a - high_a;
  assign wrap    = run && !clear && (cnt_q == div_a - CW'(1));

  // clk_out is computed from the next count so the flop lines up with cnt_q.
  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clear || !run || wrap) cnt_d = '0;
    clk_out_d = run && !clear && !wrap && (cnt_d >= low_len);
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      clk_out_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      clk_out_q <= clk_out_d;
    end
  end

  assign clk_out = clk_out_q;

endmodule

// File: rtl/clk_div_ctrl.sv
// Divider controller: owns the run FSM, active/shadow configuration and the
// host handshake; new settings take effect only at period boundaries.
module clk_div_ctrl
  import clk_div_pkg::*;
#(
  parameter int CW       = 8,
  parameter int DEF_DIV  = CLK_DEF_DIV,
  parameter int DEF_HIGH = CLK_DEF_HIGH
) (
  input  logic          clk_in,
  input  logic          rst,
  input  logic          en,
  input  logic          cfg_valid,
  input  logic [CW-1:0] cfg_div,
  input  logic [CW-1:0] cfg_high,
  output logic          cfg_ready,
  output logic          cfg_err,
  output logic          clk_out,
  output logic          period_tick,
  output logic          running
);

  state_e        state_q, state_d;
  logic [CW-1:0] div_q, div_d, high_q, high_d;
  logic [CW-1:0] sdiv_q, sdiv_d, shigh_q, shigh_d;
  logic          cfg_err_q, cfg_err_d;
  logic          tick_q;
  logic          accept, legal, legal_acc;
  logic          core_run, core_clear, wrap;

  assign cfg_ready  = (state_q != ST_PEND);
  assign running    = (state_q != ST_IDLE);
  assign accept     = cfg_valid && cfg_ready;
  assign legal      = cfg_legal(32'(cfg_div), 32'(cfg_high));
  assign legal_acc  = accept && legal;
  assign core_run   = (state_q != ST_IDLE);
  assign core_clear = (state_q == ST_IDLE);

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    high_d    = high_q;
    sdiv_d    = sdiv_q;
    shigh_d   = shigh_q;
    cfg_err_d = accept && !legal;
    case (state_q)
      ST_IDLE: begin
        if (legal_acc) begin
          div_d  = cfg_div;
          high_d = cfg_high;
        end
        if (en) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (legal_acc) begin
          sdiv_d  = cfg_div;
          shigh_d = cfg_high;
          state_d = ST_PEND;
        end else if (!en) begin
          state_d = ST_DRAIN;
        end
      end
      ST_PEND: begin
        if (wrap) begin
          div_d   = sdiv_q;
          high_d  = shigh_q;
          state_d = en ? ST_RUN : ST_IDLE;
        end
      end
      ST_DRAIN: begin
        // An accept landing on the wrap cycle is already at a boundary.
        if (wrap) begin
          if (legal_acc) begin
            div_d  = cfg_div;
            high_d = cfg_high;
          end
          state_d = en ? ST_RUN : ST_IDLE;
        end else if (legal_acc) begin
          sdiv_d  = cfg_div;
          shigh_d = cfg_high;
          state_d = ST_PEND;
        end else if (en) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      div_q     <= CW'(DEF_DIV);
      high_q    <= CW'(DEF_HIGH);
      sdiv_q    <= '0;
      shigh_q   <= '0;
      cfg_err_q <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      high_q    <= high_d;
      sdiv_q    <= sdiv_d;
      shigh_q   <= shigh_d;
      cfg_err_q <= cfg_err_d;
      tick_q    <= wrap;
    end
  end

  clk_div_core #(.CW(CW)) u_core (
    .clk_in  (clk_in),
    .rst     (rst),
    .run     (core_run),
    .clear   (core_clear),
    .div_a   (div_q),
    .high_a  (high_q),
    .clk_out (clk_out),
    .wrap    (wrap)
  );

  assign cfg_err     = cfg_err_q;
  assign period_tick = tick_q;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Directed bench for clk_div_ctrl: hand-computed waveforms checked with
// immediate assertions one cycle at a time.
module tb_clk_div_ctrl;

  logic       clk_in = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       cfg_valid = 1'b0;
  logic [7:0] cfg_div = 8'd0;
  logic [7:0] cfg_high = 8'd0;
  logic       cfg_ready, cfg_err, clk_out, period_tick, running;

  int n_chk = 0;
  int n_err = 0;

  logic [8:0] c_clk, c_tick, c_rdy;

  clk_div_ctrl #(.CW(8), .DEF_DIV(6), .DEF_HIGH(2)) dut (
    .clk_in      (clk_in),
    .rst         (rst),
    .en          (en),
    .cfg_valid   (cfg_valid),
    .cfg_div     (cfg_div),
    .cfg_high    (cfg_high),
    .cfg_ready   (cfg_ready),
    .cfg_err     (cfg_err),
    .clk_out     (clk_out),
    .period_tick (period_tick),
    .running     (running)
  );

  always #5 clk_in = ~clk_in;

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic reset_dut();
    en = 1'b0;
    cfg_valid = 1'b0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    // Expected PEND/reload waveform from the 6/2 -> 3/1 change accepted at cnt=2
    c_clk  = 9'b100100110;
    c_tick = 9'b001001000;
    c_rdy  = 9'b111111000;

    // Reset state
    en = 1'b0;
    rst = 1'b1;
    step();
    step();
    chk("rst_clk_out", clk_out, 1'b0);
    chk("rst_tick", period_tick, 1'b0);
    chk("rst_err", cfg_err, 1'b0);
    chk("rst_running", running, 1'b0);
    chk("rst_ready", cfg_ready, 1'b1);
    rst = 1'b0;

    // Default 6/2 pattern
    en = 1'b1;
    step();
    for (int i = 0; i < 12; i++) begin
      chk("def_clk", clk_out, (i % 6) >= 4);
      chk("def_tick", period_tick, (i >= 6) && (i % 6 == 0));
      chk("def_running", running, 1'b1);
      step();
    end

    // Config 4/2 in IDLE, then run
    reset_dut();
    cfg_valid = 1'b1; cfg_div = 8'd4; cfg_high = 8'd2;
    step();
    chk("idle_cfg_err", cfg_err, 1'b0);
    chk("idle_cfg_running", running, 1'b0);
    chk("idle_cfg_clk", clk_out, 1'b0);
    cfg_valid = 1'b0;
    en = 1'b1;
    step();
    for (int i = 0; i < 8; i++) begin
      chk("d4_clk", clk_out, (i % 4) >= 2);
      chk("d4_tick", period_tick, i == 4);
      chk("d4_ready", cfg_ready, 1'b1);
      step();
    end

    // Runtime change to 3/1 accepted at cnt=2
    reset_dut();
    en = 1'b1;
    step();
    step();
    step();
    chk("pre_acc_ready", cfg_ready, 1'b1);
    cfg_valid = 1'b1; cfg_div = 8'd3; cfg_high = 8'd1;
    step();
    cfg_valid = 1'b0;
    for (int k = 0; k < 9; k++) begin
      chk("pend_clk", clk_out, c_clk[k]);
      chk("pend_tick", period_tick, c_tick[k]);
      chk("pend_ready", cfg_ready, c_rdy[k]);
      step();
    end

    // Illegal configs: 5/5 then 1/0
    reset_dut();
    en = 1'b1;
    step();
    cfg_valid = 1'b1; cfg_div = 8'd5; cfg_high = 8'd5;
    step();
    chk("ill55_err", cfg_err, 1'b1);
    chk("ill55_ready", cfg_ready, 1'b1);
    cfg_valid = 1'b0;
    step();
    chk("ill55_err_clr", cfg_err, 1'b0);
    cfg_valid = 1'b1; cfg_div = 8'd1; cfg_high = 8'd0;
    step();
    chk("ill10_err", cfg_err, 1'b1);
    chk("ill_cnt3_clk", clk_out, 1'b0);
    cfg_valid = 1'b0;
    step();
    chk("ill10_err_clr", cfg_err, 1'b0);
    chk("ill_cnt4_clk", clk_out, 1'b1);
    step();
    chk("ill_cnt5_clk", clk_out, 1'b1);
    chk("ill_ready", cfg_ready, 1'b1);
    step();
    chk("ill_wrap_tick", period_tick, 1'b1);
    chk("ill_wrap_clk", clk_out, 1'b0);
    for (int i = 0; i < 4; i++) step();
    chk("ill_next_cnt4_clk", clk_out, 1'b1);

    // Divide-by-2, config and en on the same IDLE cycle
    reset_dut();
    cfg_valid = 1'b1; cfg_div = 8'd2; cfg_high = 8'd1;
    en = 1'b1;
    step();
    cfg_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk("d2_clk", clk_out, (i % 2) == 1);
      chk("d2_tick", period_tick, (i >= 2) && (i % 2 == 0));
      step();
    end

    // en dropped at cnt=1 -> drain to end of period
    reset_dut();
    en = 1'b1;
    step();
    step();
    en = 1'b0;
    step();
    chk("drain_running", running, 1'b1);
    chk("drain_cnt2_clk", clk_out, 1'b0);
    step();
    chk("drain_cnt3_clk", clk_out, 1'b0);
    step();
    chk("drain_cnt4_clk", clk_out, 1'b1);
    step();
    chk("drain_cnt5_clk", clk_out, 1'b1);
    chk("drain_cnt5_running", running, 1'b1);
    step();
    chk("drain_end_clk", clk_out, 1'b0);
    chk("drain_end_running", running, 1'b0);
    chk("drain_end_tick", period_tick, 1'b1);
    step();
    chk("idle_tick", period_tick, 1'b0);
    chk("idle_clk", clk_out, 1'b0);
    chk("idle_running", running, 1'b0);

    // en dropped during PEND -> config applied, then IDLE
    reset_dut();
    en = 1'b1;
    step();
    cfg_valid = 1'b1; cfg_div = 8'd3; cfg_high = 8'd1;
    step();
    chk("pdrop_ready", cfg_ready, 1'b0);
    cfg_valid = 1'b0;
    en = 1'b0;
    step();
    chk("pdrop_running", running, 1'b1);
    chk("pdrop_ready2", cfg_ready, 1'b0);
    step();
    step();
    chk("pdrop_cnt4_clk", clk_out, 1'b1);
    step();
    step();
    chk("pdrop_end_running", running, 1'b0);
    chk("pdrop_end_ready", cfg_ready, 1'b1);
    chk("pdrop_end_clk", clk_out, 1'b0);
    en = 1'b1;
    step();
    chk("pdrop_new_cnt0", clk_out, 1'b0);
    step();
    chk("pdrop_new_cnt1", clk_out, 1'b0);
    step();
    chk("pdrop_new_cnt2", clk_out, 1'b1);
    step();
    chk("pdrop_new_tick", period_tick, 1'b1);

    // Asynchronous reset in the high phase while a config is pending
    reset_dut();
    en = 1'b1;
    step();
    step();
    cfg_valid = 1'b1; cfg_div = 8'd3; cfg_high = 8'd1;
    step();
    cfg_valid = 1'b0;
    step();
    step();
    chk("arst_pre_clk", clk_out, 1'b1);
    chk("arst_pre_ready", cfg_ready, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_clk", clk_out, 1'b0);
    chk("arst_running", running, 1'b0);
    chk("arst_ready", cfg_ready, 1'b1);
    chk("arst_tick", period_tick, 1'b0);
    en = 1'b0;
    step();
    rst = 1'b0;
    en = 1'b1;
    step();
    for (int i = 0; i < 7; i++) begin
      chk("arst_def_clk", clk_out, (i % 6) >= 4);
      chk("arst_def_tick", period_tick, i == 6);
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
